analog_quad_encoder: RTL and testbench
======================================

Name: analog_quad_encoder

Overview:
- Converts player steering input into the two-phase quadrature signals the Sprint 1 core reads on its SteerA/SteerB inputs.
- Four input sources are supported: digital left/right, absolute paddle, analog stick (velocity) and spinner (delta packets).
- Sits between hps_io joystick/paddle/spinner outputs and the sprint1 steering inputs, clocked by the 6 MHz video clock.

Parameters:
- DEADZONE, 8: analog magnitude below this produces no steps.
- PEND_W, 10: width of the signed spinner pending-step accumulator.

Ports:
- CLK  in  1  block clock (6 MHz core video clock)
- Reset_n  in  1  asynchronous active-low reset
- clkdiv  in  16  base step tick period in CLK cycles
- mode  in  2  source select: 00 digital, 01 paddle, 10 analog, 11 spinner
- left  in  1  digital left, active high
- right  in  1  digital right, active high
- paddle  in  8  unsigned absolute paddle position
- analog  in  8  signed stick X deflection
- spinner  in  9  [7:0] signed delta, [8] toggles on each new packet
- steer  out  2  quadrature phases, [1]=A, [0]=B
- step_o  out  1  one-cycle pulse when steer changes
- dir_o  out  1  direction of last step, 1=CW/right

Behaviour:
- Reset (async, Reset_n=0): steer=00, step_o=0, dir_o=0, prescaler=0, pos=0x80, acc=0, pend=0, spin_prev=0, mode_prev=00.
- Prescaler:
  - Counts 0..clkdiv-1; tick=1 in the cycle where count==clkdiv-1, then count wraps to 0.
  - clkdiv=0 is treated as 1, i.e. tick every cycle.
- Quadrature:
  - CW sequence 00->01->11->10->00; CCW is the reverse.
  - At most one step per tick.
  - steer is registered and updates the cycle after the tick.
  - step_o is asserted in that same cycle; dir_o updates with it.
- Mode change (mode != mode_prev):
  - That cycle: no step; acc=0, pend=0, pos<=paddle.
  - steer holds its value (no glitch).
  - Prescaler keeps running.
- Digital mode: on tick, right&!left -> CW; left&!right -> CCW; both or neither -> none.
- Paddle mode:
  - On tick, paddle>pos -> CW, pos+1; paddle<pos -> CCW, pos-1; equal -> none.
  - Unsigned compare, no wrap.
- Analog mode:
  - mag = |analog|, with -128 saturated to 127.
  - mag<DEADZONE -> no steps, and acc holds.
  - Otherwise on tick: s = acc + mag (9 bit); acc <= s[7:0]; step if s[8]; direction = sign of analog (negative -> CCW).
  - Sign reversal does not clear acc.
- Spinner mode:
  - A new packet is detected when spinner[8] != spin_prev; spin_prev <= spinner[8] every cycle.
  - On packet: pend += sign-extended delta.
  - On tick: pend>0 -> CW and pend-1; pend<0 -> CCW and pend+1.
  - Packet and tick in the same cycle are both applied: pend_next = sat(pend + delta - step), with step=+1 for CW, -1 for CCW, 0 for none.
  - pend saturates to [-(2^(PEND_W-1)-1), +(2^(PEND_W-1)-1)].
  - Step direction is decided from pend before the addition.
- Reset mid-operation: all state clears immediately; output resumes from steer=00 after release.

Test Plan:
- Digital stepping: clkdiv=4, mode=00, right=1 held for 20 cycles after reset -> step_o at cycles 4,8,12,16,20; steer 01,11,10,00,01; dir_o=1.
- Paddle tracking: mode 00->01 with paddle=0x80, then paddle=0x85, clkdiv=1 -> no step in change cycle, exactly 5 CW steps, then idle; paddle=0x7E -> 7 CCW steps.
- Analog velocity: mode=10, clkdiv=1:
  - analog=0x80 -> mag 127, 127 CCW steps in 256 ticks.
  - analog=0x05 -> zero steps.
  - analog=0x40 -> 1 step every 4 ticks, CW.
- Spinner accumulation: mode=11, clkdiv=8:
  - Packet +3 (toggle bit 8), then packet -5 before the first tick -> net pend -2 -> 2 CCW steps, then idle.
  - Packet concurrent with a tick is applied exactly once.
- Spinner saturation: 10 packets of +127 (PEND_W=10) -> pend clamps at 511; exactly 511 CW steps result.
- Async reset: assert Reset_n=0 mid-sequence with steer=11 -> steer=00 and step_o=0 without a clock edge; after release, pos=0x80 and the prescaler restarts from 0.

Source files
------------

// File: rtl/analog_quad_encoder.sv
// -----------------------------------------------------------------------------
// analog_quad_encoder
//
// Turns player steering input into the two-phase quadrature pair that the
// Sprint 1 core samples on SteerA/SteerB. One of four sources is selected by
// `mode`. Every source produces at most one quadrature step per prescaler tick.
//
// Ports
//   CLK      in   1   6 MHz core video clock
//   Reset_n  in   1   asynchronous active-low reset
//   clkdiv   in  16   step tick period in CLK cycles (0 behaves as 1)
//   mode     in   2   00 digital, 01 paddle, 10 analog stick, 11 spinner
//   left     in   1   digital left, active high
//   right    in   1   digital right, active high
//   paddle   in   8   unsigned absolute paddle position
//   analog   in   8   signed stick X deflection
//   spinner  in   9   [7:0] signed delta, [8] toggles once per new packet
//   steer    out  2   quadrature phases, [1]=A, [0]=B
//   step_o   out  1   one-cycle pulse in the cycle steer changes
//   dir_o    out  1   direction of the most recent step, 1 = CW/right
// -----------------------------------------------------------------------------
module analog_quad_encoder #(
    parameter int DEADZONE = 8,
    parameter int PEND_W   = 10
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic [15:0]       clkdiv,
    input  logic [1:0]        mode,
    input  logic              left,
    input  logic              right,
    input  logic [7:0]        paddle,
    input  logic signed [7:0] analog,
    input  logic [8:0]        spinner,
    output logic [1:0]        steer,
    output logic              step_o,
    output logic              dir_o
);

    localparam int SUM_W    = PEND_W + 2;
    localparam int PEND_LIM = (1 << (PEND_W - 1)) - 1;

    localparam logic signed [SUM_W-1:0] LIM_HI = SUM_W'(PEND_LIM);
    localparam logic signed [SUM_W-1:0] LIM_LO = -LIM_HI;
    localparam logic [7:0]              DZ     = 8'(DEADZONE);

    localparam logic [1:0] MODE_DIG = 2'b00;
    localparam logic [1:0] MODE_PAD = 2'b01;
    localparam logic [1:0] MODE_ANA = 2'b10;

    // Next quadrature code. CW walks 00->01->11->10->00, CCW the reverse.
    function automatic logic [1:0] quad_next(input logic [1:0] cur, input logic cw);
        logic [1:0] nxt;
        case (cur)
            2'b00:   nxt = cw ? 2'b01 : 2'b10;
            2'b01:   nxt = cw ? 2'b11 : 2'b00;
            2'b11:   nxt = cw ? 2'b10 : 2'b01;
            default: nxt = cw ? 2'b00 : 2'b11;
        endcase
        return nxt;
    endfunction

    // Stick magnitude; -128 has no positive twin in 8 bits, so it maps to 127.
    function automatic logic [7:0] abs_sat(input logic signed [7:0] v);
        logic [7:0] m;
        if (v == -8'sd128)
            m = 8'd127;
        else if (v[7])
            m = 8'(-v);
        else
            m = 8'(v);
        return m;
    endfunction

    // Clamp the widened pending-step sum back into the symmetric PEND_W range.
    function automatic logic signed [PEND_W-1:0] sat_pend(input logic signed [SUM_W-1:0] v);
        logic signed [PEND_W-1:0] r;
        if (v > LIM_HI)
            r = PEND_W'(LIM_HI);
        else if (v < LIM_LO)
            r = PEND_W'(LIM_LO);
        else
            r = PEND_W'(v);
        return r;
    endfunction

    // State
    logic [15:0]              cnt;
    logic [7:0]               pos;
    logic [7:0]               acc;
    logic signed [PEND_W-1:0] pend;
    logic                     spin_prev;
    logic [1:0]               mode_prev;

    // Output stage registers
    logic [1:0] steer_p1;
    logic       vld_p1;
    logic       dir_p1;

    // Stage 0 decisions
    logic                     tick;
    logic [15:0]              div_last;
    logic                     mode_chg;
    logic                     pkt;
    logic [7:0]               mag;
    logic signed [7:0]        delta;
    logic                     step_p0;
    logic                     cw_p0;
    logic [7:0]               pos_n;
    logic [7:0]               acc_n;
    logic signed [PEND_W-1:0] pend_n;
    logic [8:0]               asum;
    logic signed [SUM_W-1:0]  sstep;
    logic signed [SUM_W-1:0]  sadd;

    // A zero period still ticks every cycle. The >= compare keeps the counter
    // from running through 64k cycles if clkdiv is lowered below the count.
    assign div_last = (clkdiv == 16'd0) ? 16'd0 : clkdiv - 16'd1;
    assign tick     = (cnt >= div_last);

    assign mode_chg = (mode != mode_prev);
    assign pkt      = (spinner[8] != spin_prev);
    assign mag      = abs_sat(analog);
    assign delta    = spinner[7:0];

    // ---- stage 0: per-source step decision and state update ----
    always_comb begin
        step_p0 = 1'b0;
        cw_p0   = 1'b0;
        pos_n   = pos;
        acc_n   = acc;
        pend_n  = pend;
        asum    = {1'b0, acc} + {1'b0, mag};
        sstep   = '0;
        sadd    = pkt ? SUM_W'(delta) : '0;

        if (mode_chg) begin
            // Source switch: drop stale motion and re-anchor the paddle so the
            // new source starts from rest. The tick of this cycle is lost.
            acc_n  = '0;
            pend_n = '0;
            pos_n  = paddle;
        end else begin
            case (mode)
                MODE_DIG: begin
                    if (tick) begin
                        if (right && !left) begin
                            step_p0 = 1'b1;
                            cw_p0   = 1'b1;
                        end else if (left && !right) begin
                            step_p0 = 1'b1;
                        end
                    end
                end
                MODE_PAD: begin
                    if (tick) begin
                        if (paddle > pos) begin
                            step_p0 = 1'b1;
                            cw_p0   = 1'b1;
                            pos_n   = pos + 8'd1;
                        end else if (paddle < pos) begin
                            step_p0 = 1'b1;
                            pos_n   = pos - 8'd1;
                        end
                    end
                end
                MODE_ANA: begin
                    // Phase accumulator: carry out of 8 bits is a step, so
                    // step rate is mag/256 per tick. Inside the dead zone acc
                    // is frozen rather than cleared.
                    if (tick && (mag >= DZ)) begin
                        acc_n   = asum[7:0];
                        step_p0 = asum[8];
                        cw_p0   = ~analog[7];
                    end
                end
                default: begin
                    // Direction comes from pend before this cycle's packet.
                    if (tick && !pend[PEND_W-1] && (pend != '0)) begin
                        step_p0 = 1'b1;
                        cw_p0   = 1'b1;
                        sstep   = SUM_W'(1);
                    end else if (tick && pend[PEND_W-1]) begin
                        step_p0 = 1'b1;
                        sstep   = '1;
                    end
                    pend_n = sat_pend(SUM_W'(pend) + sadd - sstep);
                end
            endcase
        end
    end

    // ---- stage 1: registered quadrature output ----
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt       <= '0;
            pos       <= 8'h80;
            acc       <= '0;
            pend      <= '0;
            spin_prev <= 1'b0;
            mode_prev <= 2'b00;
            steer_p1  <= 2'b00;
            vld_p1    <= 1'b0;
            dir_p1    <= 1'b0;
        end else begin
            cnt       <= tick ? 16'd0 : cnt + 16'd1;
            pos       <= pos_n;
            acc       <= acc_n;
            pend      <= pend_n;
            spin_prev <= spinner[8];
            mode_prev <= mode;
            vld_p1    <= step_p0;
            if (step_p0) begin
                steer_p1 <= quad_next(steer_p1, cw_p0);
                dir_p1   <= cw_p0;
            end
        end
    end

    assign steer  = steer_p1;
    assign step_o = vld_p1;
    assign dir_o  = dir_p1;

endmodule

// File: tb/tb_analog_quad_encoder.sv
`timescale 1ns/1ps
module tb_analog_quad_encoder;

    logic              CLK = 1'b0;
    logic              Reset_n = 1'b1;
    logic [15:0]       clkdiv = 16'd4;
    logic [1:0]        mode = 2'b00;
    logic              left = 1'b0;
    logic              right = 1'b0;
    logic [7:0]        paddle = 8'h80;
    logic signed [7:0] analog = 8'sd0;
    logic [8:0]        spinner = 9'd0;
    logic [1:0]        steer;
    logic              step_o;
    logic              dir_o;

    always #5 CLK = ~CLK;

    analog_quad_encoder #(.DEADZONE(8), .PEND_W(10)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .clkdiv(clkdiv), .mode(mode),
        .left(left), .right(right), .paddle(paddle), .analog(analog),
        .spinner(spinner), .steer(steer), .step_o(step_o), .dir_o(dir_o)
    );

    typedef struct {
        int         cyc;
        logic [1:0] st;
        logic       dir;
    } exp_t;

    exp_t       q[$];
    int         tests = 0;
    int         fails = 0;
    int         edge_n = 0;
    logic [1:0] last_steer = 2'b00;
    int         cw_seen = 0;
    int         ccw_seen = 0;

    // Reference model state: a signed position count, not a quadrature code.
    int         m_k, m_phase, m_pos, m_acc, m_pend;
    logic       m_sp;
    logic [1:0] m_mode;

    function automatic logic [1:0] gray(input int p);
        int r;
        logic [1:0] g;
        r = ((p % 4) + 4) % 4;
        case (r)
            0:       g = 2'b00;
            1:       g = 2'b01;
            2:       g = 2'b11;
            default: g = 2'b10;
        endcase
        return g;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        m_k = 0; m_phase = 0; m_pos = 128; m_acc = 0; m_pend = 0;
        m_sp = 1'b0; m_mode = 2'b00;
    endtask

    // Predicts the effect of the coming rising edge from the current inputs.
    task automatic model_edge();
        int  d, div, mag, dv;
        bit  tick, pkt;
        d = 0;
        div = (clkdiv == 16'd0) ? 1 : int'(clkdiv);
        tick = ((m_k % div) == div - 1);
        m_k++;
        pkt = (spinner[8] != m_sp);
        m_sp = spinner[8];
        if (mode != m_mode) begin
            m_acc = 0; m_pend = 0; m_pos = int'(paddle);
        end else begin
            case (mode)
                2'b00: if (tick) begin
                    if (right && !left) d = 1;
                    else if (left && !right) d = -1;
                end
                2'b01: if (tick) begin
                    if (int'(paddle) > m_pos) begin d = 1; m_pos++; end
                    else if (int'(paddle) < m_pos) begin d = -1; m_pos--; end
                end
                2'b10: begin
                    mag = (analog < 0) ? -int'(analog) : int'(analog);
                    if (mag > 127) mag = 127;
                    if (tick && mag >= 8) begin
                        m_acc += mag;
                        if (m_acc >= 256) begin
                            m_acc -= 256;
                            d = (analog < 0) ? -1 : 1;
                        end
                    end
                end
                default: begin
                    if (tick) d = (m_pend > 0) ? 1 : ((m_pend < 0) ? -1 : 0);
                    dv = pkt ? int'($signed(spinner[7:0])) : 0;
                    m_pend = m_pend + dv - d;
                    if (m_pend > 511) m_pend = 511;
                    if (m_pend < -511) m_pend = -511;
                end
            endcase
        end
        m_mode = mode;
        if (d != 0) begin
            m_phase += d;
            q.push_back('{edge_n + 1, gray(m_phase), (d > 0)});
        end
    endtask

    task automatic cyc_run();
        model_edge();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Called with CLK low; the reset is observed before any clock edge.
    task automatic do_reset();
        Reset_n = 1'b0;
        #1;
        check("rst_steer", int'(steer), 0);
        check("rst_step", int'(step_o), 0);
        check("rst_dir", int'(dir_o), 0);
        @(posedge CLK);
        @(negedge CLK);
        check("queue_empty_at_reset", q.size(), 0);
        q.delete();
        model_reset();
        last_steer = 2'b00;
        Reset_n = 1'b1;
    endtask

    task automatic clr_counts();
        cw_seen = 0;
        ccw_seen = 0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT emits a step.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            edge_n++;
            #1;
            if (!Reset_n) begin
                last_steer = 2'b00;
            end else if (step_o) begin
                if (dir_o) cw_seen++; else ccw_seen++;
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_step: step_o=1 steer=%b, expected no step (edge %0d)", steer, edge_n);
                end else begin
                    e = q.pop_front();
                    check("step_edge", edge_n, e.cyc);
                    check("step_steer", int'(steer), int'(e.st));
                    check("step_dir", int'(dir_o), int'(e.dir));
                    last_steer = e.st;
                end
            end else begin
                check("steer_hold", int'(steer), int'(last_steer));
                if (q.size() > 0 && q[0].cyc <= edge_n) begin
                    tests++;
                    fails++;
                    $display("FAIL missing_step: step_o=0, expected step to %b (edge %0d)", q[0].st, edge_n);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        @(negedge CLK);

        // Digital stepping
        clkdiv = 16'd4; mode = 2'b00; right = 1'b0; left = 1'b0;
        do_reset();
        right = 1'b1; clr_counts();
        repeat (20) cyc_run();
        check("dig_cw", cw_seen, 5);
        check("dig_ccw", ccw_seen, 0);

        // Paddle tracking
        right = 1'b0; clkdiv = 16'd1; mode = 2'b00; paddle = 8'h80;
        do_reset();
        mode = 2'b01; clr_counts();
        cyc_run();
        check("pad_change_nostep", cw_seen + ccw_seen, 0);
        paddle = 8'h85; clr_counts();
        repeat (12) cyc_run();
        check("pad_cw", cw_seen, 5);
        check("pad_cw_ccw", ccw_seen, 0);
        paddle = 8'h7E; clr_counts();
        repeat (12) cyc_run();
        check("pad_ccw", ccw_seen, 7);
        check("pad_ccw_cw", cw_seen, 0);

        // Analog velocity
        clkdiv = 16'd1; mode = 2'b00; analog = 8'sd0;
        do_reset();
        mode = 2'b10; analog = -8'sd128;
        cyc_run();
        clr_counts();
        repeat (256) cyc_run();
        check("ana_full_ccw", ccw_seen, 127);
        check("ana_full_cw", cw_seen, 0);
        analog = 8'sd5; clr_counts();
        repeat (64) cyc_run();
        check("ana_deadzone", cw_seen + ccw_seen, 0);
        analog = 8'sd64; clr_counts();
        repeat (64) cyc_run();
        check("ana_quarter_cw", cw_seen, 16);
        check("ana_quarter_ccw", ccw_seen, 0);

        // Spinner accumulation, including a packet landing on a tick (i=31)
        clkdiv = 16'd8; mode = 2'b00; analog = 8'sd0; spinner = 9'd0;
        do_reset();
        mode = 2'b11; clr_counts();
        for (int i = 0; i < 64; i++) begin
            if (i == 1)  spinner = {1'b1, 8'd3};
            if (i == 2)  spinner = {1'b0, 8'hFB};
            if (i == 25) begin
                check("spin_net_ccw", ccw_seen, 2);
                check("spin_net_cw", cw_seen, 0);
                clr_counts();
                spinner = {1'b1, 8'd1};
            end
            if (i == 31) spinner = {1'b0, 8'd3};
            cyc_run();
        end
        check("spin_concurrent_cw", cw_seen, 4);
        check("spin_concurrent_ccw", ccw_seen, 0);

        // Spinner saturation
        clkdiv = 16'd16; mode = 2'b00; spinner = 9'd0;
        do_reset();
        mode = 2'b11; clr_counts();
        for (int i = 0; i < 511 * 16 + 40; i++) begin
            if (i >= 1 && i <= 10) spinner = {~spinner[8], 8'd127};
            cyc_run();
        end
        check("spin_sat_cw", cw_seen, 511);
        check("spin_sat_ccw", ccw_seen, 0);

        // Async reset mid-sequence while steer=11 and step_o is high
        clkdiv = 16'd4; mode = 2'b00; right = 1'b1; spinner = 9'd0;
        do_reset();
        repeat (7) cyc_run();
        model_edge();
        @(posedge CLK);
        #2;
        check("pre_reset_steer", int'(steer), 3);
        check("pre_reset_step", int'(step_o), 1);
        Reset_n = 1'b0;
        #1;
        check("async_rst_steer", int'(steer), 0);
        check("async_rst_step", int'(step_o), 0);
        check("async_rst_dir", int'(dir_o), 0);
        @(negedge CLK);
        check("queue_empty_mid_reset", q.size(), 0);
        q.delete();
        model_reset();
        last_steer = 2'b00;
        Reset_n = 1'b1;
        clr_counts();
        repeat (8) cyc_run();
        check("post_reset_cw", cw_seen, 2);

        // Randomized mixed traffic
        for (int r = 0; r < 6; r++) begin
            clkdiv = 16'($urandom_range(0, 5));
            mode = 2'b00; right = 1'b0; left = 1'b0; spinner = 9'd0;
            do_reset();
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
                left = 1'($urandom);
                right = 1'($urandom);
                if ($urandom_range(0, 9) == 0) paddle = 8'($urandom);
                if ($urandom_range(0, 19) == 0) analog = 8'($urandom);
                if ($urandom_range(0, 5) == 0) spinner = {~spinner[8], 8'($urandom)};
                cyc_run();
            end
            check("rand_queue_drained", q.size(), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
